// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the Y86-64 fetch stage: fetch PC out, 10-byte window and error back.
interface fetch_stage_if;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;

  modport master (output imem_addr, input imem_data, input imem_error);
  modport slave  (input imem_addr, output imem_data, output imem_error);
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split, valP/predicted-PC generation and the F/D registers.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          F_stall,
  input  logic          D_stall,
  input  logic          D_bubble,
  input  logic [3:0]    M_icode,
  input  logic          M_Cnd,
  input  logic [63:0]   M_valA,
  input  logic [3:0]    W_icode,
  input  logic [63:0]   W_valM,
  fetch_stage_if.master imem,
  output logic [63:0]   F_predPC,
  output logic [2:0]    D_stat,
  output logic [3:0]    D_icode,
  output logic [3:0]    D_ifun,
  output logic [3:0]    D_rA,
  output logic [3:0]    D_rB,
  output logic [63:0]   D_valC,
  output logic [63:0]   D_valP
);
  localparam int unsigned XLEN = 64;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_MAX  = 4'hB;
  localparam logic [3:0] RNONE  = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef struct packed {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] valp;
  } dreg_t;

  localparam dreg_t D_NOP = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
                              valc: XLEN'(0), valp: XLEN'(0)};

  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_predpc;
  logic [3:0]      raw_icode;
  logic [3:0]      raw_ifun;
  logic            need_regids;
  logic            need_valc;
  dreg_t           f_d;
  dreg_t           d_q;

  // Mispredicted jXX outranks ret; otherwise fetch from the prediction
  always_comb begin
    f_pc = F_predPC;
    if (M_icode == I_JXX && !M_Cnd)
      f_pc = M_valA;
    else if (W_icode == I_RET)
      f_pc = W_valM;
  end

  assign imem.imem_addr = f_pc;

  // Field split, status, valP and next-PC prediction
  always_comb begin
    raw_icode   = imem.imem_data[7:4];
    raw_ifun    = imem.imem_data[3:0];
    need_regids = raw_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = raw_icode inside {4'h3, 4'h4, 4'h5, I_JXX, I_CALL};

    f_d       = D_NOP;
    f_d.icode = raw_icode;
    f_d.ifun  = raw_ifun;
    if (need_regids) begin
      f_d.ra = imem.imem_data[15:12];
      f_d.rb = imem.imem_data[11:8];
    end
    if (need_valc)
      f_d.valc = need_regids ? imem.imem_data[79:16] : imem.imem_data[71:8];
    f_d.valp = f_pc + XLEN'(1) + XLEN'(need_regids) + (need_valc ? XLEN'(8) : XLEN'(0));

    if (imem.imem_error) begin
      f_d.stat  = S_ADR;
      f_d.icode = I_NOP;
      f_d.ifun  = 4'h0;
    end else if (raw_icode > I_MAX) begin
      f_d.stat = S_INS;
    end else if (raw_icode == I_HALT) begin
      f_d.stat = S_HLT;
    end else begin
      f_d.stat = S_AOK;
    end

    f_predpc = (raw_icode == I_JXX || raw_icode == I_CALL) ? f_d.valc : f_d.valp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      F_predPC <= RESET_PC;
    else if (!F_stall)
      F_predPC <= f_predpc;
  end

  // Stall holds, bubble injects a nop, otherwise capture the fetched instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      d_q <= D_NOP;
    else if (!D_stall)
      d_q <= D_bubble ? D_NOP : f_d;
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed instruction windows with hand-computed D/F contents.
module tb_fetch_stage;
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [63:0] predpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t last;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
    .imem(imem_bus.master), .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc,
                              input logic [63:0] valp, input logic [63:0] predpc);
    exp_t e;
    e.stat = stat; e.icode = icode; e.ifun = ifun; e.ra = ra; e.rb = rb;
    e.valc = valc; e.valp = valp; e.predpc = predpc;
    return e;
  endfunction

  // Inputs are already applied at this negedge; the next posedge captures them
  task automatic issue(input exp_t e);
    sb.push_back(e);
    last = e;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_predpc"}, F_predPC, 64'd0);
    chk({tag, "_stat"},   64'(D_stat), 64'd1);
    chk({tag, "_icode"},  64'(D_icode), 64'd1);
    chk({tag, "_ifun"},   64'(D_ifun), 64'd0);
    chk({tag, "_ra"},     64'(D_rA), 64'hF);
    chk({tag, "_rb"},     64'(D_rB), 64'hF);
    chk({tag, "_valc"},   D_valC, 64'd0);
    chk({tag, "_valp"},   D_valP, 64'd0);
  endtask

  // Monitor: D/F registers are checked once per cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("d_stat",  64'(D_stat),  64'(e.stat));
        chk("d_icode", 64'(D_icode), 64'(e.icode));
        chk("d_ifun",  64'(D_ifun),  64'(e.ifun));
        chk("d_ra",    64'(D_rA),    64'(e.ra));
        chk("d_rb",    64'(D_rB),    64'(e.rb));
        chk("d_valc",  D_valC,       e.valc);
        chk("d_valp",  D_valP,       e.valp);
        chk("f_predpc", F_predPC,    e.predpc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'd0; W_icode = 4'h0; W_valM = 64'd0;
    imem_bus.imem_data = 80'd0; imem_bus.imem_error = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // irmovq $0x1122334455667788,%rbx at PC 0
    imem_bus.imem_data = {64'h1122334455667788, 8'hF3, 8'h30};
    #1 chk("addr_irmov", imem_bus.imem_addr, 64'd0);
    issue(mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'd10, 64'd10));

    // jmp 0x20 at PC 0xA
    imem_bus.imem_data = {8'h00, 64'h20, 8'h70};
    issue(mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13, 64'h20));

    // jXX 0x100 at PC 0x20
    imem_bus.imem_data = {8'h00, 64'h100, 8'h70};
    #1 chk("addr_jxx", imem_bus.imem_addr, 64'h20);
    issue(mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100));

    // Mispredict redirects to 0x29, where a ret is fetched
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29;
    imem_bus.imem_data = 80'h90;
    #1 chk("addr_mispredict", imem_bus.imem_addr, 64'h29);
    issue(mk(3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h2A, 64'h2A));

    // ret in W; taken jXX in M does not redirect; not-taken jXX beats ret
    M_icode = 4'h0; M_valA = 64'd0;
    W_icode = 4'h9; W_valM = 64'h400;
    #1 chk("addr_ret", imem_bus.imem_addr, 64'h400);
    M_icode = 4'h7; M_Cnd = 1'b1; M_valA = 64'h55;
    #1 chk("addr_ret_taken_jxx", imem_bus.imem_addr, 64'h400);
    M_Cnd = 1'b0;
    #1 chk("addr_jxx_over_ret", imem_bus.imem_addr, 64'h55);
    imem_bus.imem_data = 80'h1220;
    issue(mk(3'd1, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h57, 64'h57));

    // Two stall cycles hold everything; D_stall outranks D_bubble on the second
    M_icode = 4'h0; M_valA = 64'd0; W_icode = 4'h0; W_valM = 64'd0;
    F_stall = 1'b1; D_stall = 1'b1;
    imem_bus.imem_data = 80'h00;
    #1 chk("addr_stall", imem_bus.imem_addr, 64'h57);
    issue(last);
    D_bubble = 1'b1;
    issue(last);

    // Bubble into D while F advances past a nop
    F_stall = 1'b0; D_stall = 1'b0;
    imem_bus.imem_data = 80'h10;
    issue(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'h58));
    D_bubble = 1'b0;

    // Invalid icode, halt, then address error over a halt byte
    imem_bus.imem_data = 80'hC0;
    issue(mk(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h59, 64'h59));
    imem_bus.imem_data = 80'h00;
    issue(mk(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h5A, 64'h5A));
    imem_bus.imem_error = 1'b1;
    issue(mk(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h5B, 64'h5B));
    imem_bus.imem_error = 1'b0;

    // Jump to the top of memory; a nop there wraps valP to 0
    imem_bus.imem_data = {8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'h70};
    issue(mk(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h64, 64'hFFFF_FFFF_FFFF_FFFF));
    imem_bus.imem_data = 80'h10;
    #1 chk("addr_top", imem_bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0));

    imem_bus.imem_data = {64'h1122334455667788, 8'hF3, 8'h30};
    issue(mk(3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788, 64'd10, 64'd10));
    chk("sb_drain", 64'(sb.size()), 64'd0);

    // Mid-cycle asynchronous reset
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    chk("addr_async_rst", imem_bus.imem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_bus.imem_data = 80'h10;
    #1 chk("addr_restart", imem_bus.imem_addr, 64'd0);
    issue(mk(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd1));
    @(negedge clk);
    chk("sb_final", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 5-stage Y86-64 pipeline. Sits directly upstream of the decode stage and consumes the PC-update information produced by later stages.
- Holds the predicted-PC register and selects the fetch PC: predicted PC, mispredicted-branch fall-through, or return address.
- Splits the 10-byte instruction window into fields, computes valP and the next predicted PC, and drives the F/D pipeline register with stall/bubble control.

Parameters:
- RESET_PC, 64'd0, value loaded into F_predPC on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- F_stall  in  1  hold F_predPC.
- D_stall  in  1  hold all D_* registers.
- D_bubble  in  1  load nop bubble into D_* registers.
- M_icode  in  4  icode in memory stage.
- M_Cnd  in  1  branch condition in memory stage.
- M_valA  in  64  fall-through PC carried by a jXX in memory stage.
- W_icode  in  4  icode in write-back stage.
- W_valM  in  64  return address read by a ret.
- imem_addr  out  64  combinational fetch PC (f_pc).
- imem_data  in  80  bytes imem_addr..imem_addr+9; byte 0 in bits [7:0].
- imem_error  in  1  fetch address invalid.
- F_predPC  out  64  registered predicted PC.
- D_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- D_icode, D_ifun, D_rA, D_rB  out  4 each  decoded fields.
- D_valC  out  64  constant word.
- D_valP  out  64  fall-through PC.

Behaviour:
- Reset (rst_n low, asynchronous, overrides everything): F_predPC=RESET_PC. D_stat=1, D_icode=1 (nop), D_ifun=0, D_rA=D_rB=4'hF, D_valC=0, D_valP=0.
- PC select, combinational, in priority order:
  - M_icode==7 && !M_Cnd → M_valA.
  - else W_icode==9 → W_valM.
  - else F_predPC.
  - Result drives imem_addr.
- Fields: icode=byte0[7:4], ifun=byte0[3:0], rA=byte1[7:4], rB=byte1[3:0].
- need_regids for icode in {2,3,4,5,6,A,B}. When need_regids is not set, rA=rB=4'hF.
- need_valC for icode in {3,4,5,7,8}.
  - valC = little-endian 8 bytes starting at byte 2 when need_regids, else starting at byte 1.
  - valC=0 when need_valC is not set.
- valP = f_pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wraps at the top of the address space, no error).
- Instruction validity: icode ≤ 4'hB is valid.
- f_stat priority: imem_error → ADR; else invalid icode → INS; else icode==0 → HLT; else AOK.
- On imem_error, D_icode is forced to 1 (nop) and D_ifun to 0. Status still carries ADR.
- Predicted next PC: icode 7 or 8 → valC; otherwise valP. This includes ret (icode 9), halt, and invalid instructions.
- F register, posedge: F_predPC ← predicted PC unless F_stall. No update during reset.
- D register, posedge:
  - D_stall → hold; D_stall takes priority over D_bubble.
  - else D_bubble → reset/bubble values.
  - else load f_stat, icode, ifun, rA, rB, valC, valP.
- Latency: an instruction fetched in cycle n appears on D_* after the posedge ending cycle n; one-cycle latency.
- Simultaneous jXX mispredict in M and ret in W: the mispredict wins, per the priority order above.
- Deassertion of rst_n mid-stream restarts fetch at RESET_PC on the next cycle.

Test Plan:
- Reset then imem_data = irmovq $0x1122334455667788,%rbx (30 F3 88 77 66 55 44 33 22 11) at PC 0 → D_icode=3, D_rA=F, D_rB=3, D_valC=64'h1122334455667788, D_valP=10, F_predPC=10.
- jXX at PC 0x20 with dest 0x100 (70 00 01 00..) → F_predPC=0x100, D_valP=0x29. Next cycle with M_icode=7, M_Cnd=0, M_valA=0x29 → imem_addr=0x29.
- ret fetched: F_predPC=valP. With W_icode=9, W_valM=0x400 → imem_addr=0x400. Same cycle with M_icode=7, M_Cnd=0, M_valA=0x55 → imem_addr=0x55.
- F_stall=1 and D_stall=1 for 2 cycles → F_predPC and all D_* unchanged. D_bubble=1 with D_stall=0 → D_icode=1, D_stat=1, D_rA=D_rB=F.
- icode 4'hC → D_stat=4. icode 0 → D_stat=2. imem_error=1 → D_stat=3, D_icode=1.
- F_predPC=64'hFFFF_FFFF_FFFF_FFFF with nop → D_valP=0, F_predPC=0. Assert rst_n low mid-cycle → outputs return to reset values immediately, without waiting for a clock edge.
